// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Purpose  : DES key schedule sequencer. Loads PC1(key) into a 28+28 bit
//            C/D register pair, rotates C and D once per round, and presents
//            PC2(C,D) as the round subkey over a valid/ready handshake.
//            Encrypt order is K1..K16, decrypt order is K16..K1.
//
// Ports    : clk          in   rising-edge clock
//            rst          in   asynchronous active-high reset
//            start        in   begin a schedule (honoured in IDLE only)
//            key[63:0]    in   raw 64-bit key, DES bit 1 = key[63]
//            decrypt      in   direction, sampled with start
//            subkey_ready in   consumer accepts the presented subkey
//            subkey[47:0] out  round subkey, DES bit 1 = subkey[47]; 0 if idle
//            subkey_valid out  subkey presented
//            round[3:0]   out  presented round, modulo 16 (see note below)
//            busy         out  schedule in progress
//            done         out  one-cycle pulse after the last accept
//            key_err      out  key parity error (DES_KS_PARITY_CHECK_EN only)
//
// Build    : define DES_KS_PARITY_CHECK_EN to refuse keys whose bytes are not
//            odd parity and to expose the key_err flag. Without it the parity
//            bits are simply dropped by PC1.
//
// Note     : the round index runs 1..16 but the port is 4 bits wide, so
//            round 16 is presented as 4'h0 with subkey_valid = 1. Idle is
//            distinguished from round 16 by subkey_valid / busy.
//
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
`ifdef DES_KS_PARITY_CHECK_EN
  ,
  output logic        key_err
`endif
);

  // DES tables, 1-based DES bit numbers of the source vector.
  localparam int c_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int c_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [4:0]  r_round;     // 0 idle, 1..16 presented round
  logic        r_dec;
  logic        r_done;

  logic [55:0] w_pc1;
  logic [47:0] w_pc2;
  logic        w_parity_ok;
  logic        w_idle;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_last;

  // DES bit b of an N-bit vector lives at vector index N-b.
  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] v;
    logic [5:0]  src;
    v = '0;
    for (int i = 0; i < 56; i++) begin
      src = 6'(64 - c_PC1[i]);
      v[6'(55 - i)] = k[src];
    end
    return v;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] v;
    logic [5:0]  src;
    v = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(56 - c_PC2[i]);
      v[6'(47 - i)] = cd[src];
    end
    return v;
  endfunction

  // Rotation amount for round r: 1 for rounds 1, 2, 9, 16, otherwise 2.
  function automatic logic f_shift2(input logic [4:0] r);
    return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  assign w_pc1 = f_pc1(key);
  assign w_pc2 = f_pc2({r_c, r_d});

`ifdef DES_KS_PARITY_CHECK_EN
  // Every key byte must carry odd parity.
  always_comb begin
    w_parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) begin
        w_parity_ok = 1'b0;
      end
    end
  end
`else
  // Parity bits (DES bits 8, 16, ..., 64) are intentionally ignored.
  logic w_unused_parity;
  assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};
  assign w_parity_ok = 1'b1;
`endif

  assign w_idle     = (r_state == ST_IDLE);
  assign w_start_ok = w_idle & start & w_parity_ok;
  assign w_accept   = (r_state == ST_ROUND) & subkey_ready;
  assign w_last     = r_dec ? (r_round == 5'd1) : (r_round == 5'd16);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs; outputs depend on registers only
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    subkey_valid = 1'b0;
    busy         = 1'b0;
    subkey       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        subkey_valid = 1'b1;
        busy         = 1'b1;
        subkey       = w_pc2;
        if (w_accept && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign round = r_round[3:0];
  assign done  = r_done;

  // --------------------------------------------------------------------------
  // C/D datapath, round counter, direction and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_dec <= decrypt;
        if (decrypt) begin
          // C16D16 equals C0D0 because the rotations total 28 bits.
          r_c     <= w_pc1[55:28];
          r_d     <= w_pc1[27:0];
          r_round <= 5'd16;
        end else begin
          r_c     <= f_rotl(w_pc1[55:28], 1'b0);
          r_d     <= f_rotl(w_pc1[27:0], 1'b0);
          r_round <= 5'd1;
        end
      end else if (w_accept) begin
        if (w_last) begin
          r_round <= 5'd0;
          r_done  <= 1'b1;
        end else if (r_dec) begin
          // Undo the shift that produced the current round.
          r_c     <= f_rotr(r_c, f_shift2(r_round));
          r_d     <= f_rotr(r_d, f_shift2(r_round));
          r_round <= r_round - 5'd1;
        end else begin
          r_c     <= f_rotl(r_c, f_shift2(r_round + 5'd1));
          r_d     <= f_rotl(r_d, f_shift2(r_round + 5'd1));
          r_round <= r_round + 5'd1;
        end
      end
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  logic r_key_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_err <= 1'b0;
    end else if (w_idle && start) begin
      // Refused start raises the flag; an accepted start clears it.
      r_key_err <= ~w_parity_ok;
    end
  end

  assign key_err = r_key_err;
`endif

endmodule
`default_nettype wire
